// File: rtl/ip_filter_cam_rw.sv
// Runtime-writable protocol-tag to destination-ID CAM with a one-stage
// registered lookup pipeline (valid/ready on both sides) and a saturating miss counter.
module ip_filter_cam_rw #(
  parameter int                  NUM_ENTRIES = 4,
  parameter int                  TAG_W       = 8,
  parameter int                  DST_ID_W    = 2,
  parameter int                  IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  parameter int                  MISS_CNT_W  = 16,
  parameter logic [TAG_W-1:0]    RST_TAG     = TAG_W'(17),
  parameter logic [DST_ID_W-1:0] RST_DST     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_val,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DST_ID_W-1:0]   wr_data,
  input  logic                  wr_valid,
  input  logic                  clr_all,
  input  logic                  rd_req_val,
  input  logic [TAG_W-1:0]      rd_req_tag,
  output logic                  rd_req_rdy,
  output logic                  rd_resp_val,
  output logic                  rd_resp_hit,
  output logic [DST_ID_W-1:0]   rd_resp_data,
  output logic [IDX_W-1:0]      rd_resp_idx,
  input  logic                  rd_resp_rdy,
  output logic [MISS_CNT_W-1:0] miss_cnt,
  input  logic                  miss_cnt_clr
);

  logic [TAG_W-1:0]    tag_q  [NUM_ENTRIES];
  logic [DST_ID_W-1:0] data_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;

  logic                wr_in_range;
  logic                req_accept;
  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic [DST_ID_W-1:0] lk_data;

  assign wr_in_range = (32'(wr_idx) < 32'(NUM_ENTRIES));
  assign rd_req_rdy  = !rd_resp_val || rd_resp_rdy;
  assign req_accept  = rd_req_val && rd_req_rdy;

  // Table storage: clr_all first, then the write so it wins for its own index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      valid_q   <= '0;
      tag_q[0]  <= RST_TAG;
      data_q[0] <= RST_DST;
      valid_q[0] <= 1'b1;
    end else begin
      if (clr_all)
        valid_q <= '0;
      if (wr_val && wr_in_range) begin
        tag_q[wr_idx]   <= wr_tag;
        data_q[wr_idx]  <= wr_data;
        valid_q[wr_idx] <= wr_valid;
      end
    end
  end

  // Priority match: scanning downward lets the lowest matching index win.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_data = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == rd_req_tag)) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_W'(i);
        lk_data = data_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_resp_val  <= 1'b0;
      rd_resp_hit  <= 1'b0;
      rd_resp_data <= '0;
      rd_resp_idx  <= '0;
    end else if (req_accept) begin
      rd_resp_val  <= 1'b1;
      rd_resp_hit  <= lk_hit;
      rd_resp_data <= lk_data;
      rd_resp_idx  <= lk_idx;
    end else if (rd_resp_rdy) begin
      rd_resp_val  <= 1'b0;
    end
  end

  // Misses are counted at accept time; a same-cycle clear takes priority.
  always_ff @(posedge clk) begin
    if (rst || miss_cnt_clr)
      miss_cnt <= '0;
    else if (req_accept && !lk_hit && (miss_cnt != '1))
      miss_cnt <= miss_cnt + 1'b1;
  end

endmodule
